// File: rtl/mem_io_ctrl.sv
// -----------------------------------------------------------------------------
// mem_io_ctrl
//   Memory/IO controller sitting between the eLC-3 datapath and the off-chip
//   SRAM plus console devices. Serves one request at a time: the control FSM
//   raises MIO_EN (with R_W, MAR, MDR) and polls the one-cycle ready pulse R.
//   Addresses xFE00..xFFFF are memory-mapped registers (KBSR, KBDR, DSR, DDR,
//   the rest read as zero); everything else goes to SRAM with WAIT_STATES
//   access cycles. MMIO accesses use identical timing but never strobe SRAM.
//
// Ports
//   Clk, Reset            clock, synchronous active-high reset
//   MIO_EN, R_W           request valid / direction (1 = write)
//   MAR, MDR              request address / write data
//   MDR_In, R             read data to MDRMUX / completion pulse
//   Mem_Addr, Mem_Wdata   registered SRAM address / write data
//   Mem_Rdata             SRAM read data
//   Mem_CE, Mem_WE        SRAM chip enable / write strobe (active-high)
//   Kbd_Valid, Kbd_Data   keyboard character strobe / character
//   Disp_Ready            display can accept a character
//   Disp_Valid, Disp_Data display character strobe / character (DDR[7:0])
// -----------------------------------------------------------------------------
module mem_io_ctrl #(
  parameter int WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MIO_EN,
  input  logic        R_W,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR,
  output logic [15:0] MDR_In,
  output logic        R,
  output logic [15:0] Mem_Addr,
  output logic [15:0] Mem_Wdata,
  input  logic [15:0] Mem_Rdata,
  output logic        Mem_CE,
  output logic        Mem_WE,
  input  logic        Kbd_Valid,
  input  logic [7:0]  Kbd_Data,
  input  logic        Disp_Ready,
  output logic        Disp_Valid,
  output logic [7:0]  Disp_Data
);

  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);
  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t      state, next_state;
  logic [3:0]  cnt;
  logic        wr_q;
  logic        kbsr_rdy;
  logic [7:0]  kbdr;
  logic        is_sram;
  logic        accept;
  logic        capture;

  // Read data for the latched address; MMIO registers shadow the top page.
  function automatic logic [15:0] rd_mux(input logic [15:0] addr,
                                         input logic [15:0] sram_d,
                                         input logic        kb_rdy,
                                         input logic [7:0]  kb_d,
                                         input logic        dsp_rdy);
    if (addr[15:9] != 7'h7F) return sram_d;
    case (addr)
      ADDR_KBSR: return {kb_rdy, 15'b0};
      ADDR_KBDR: return {8'b0, kb_d};
      ADDR_DSR:  return {dsp_rdy, 15'b0};
      default:   return 16'h0000;
    endcase
  endfunction

  assign is_sram = (Mem_Addr[15:9] != 7'h7F);

  always_comb begin
    next_state = state;
    R          = 1'b0;
    Mem_CE     = 1'b0;
    Mem_WE     = 1'b0;
    Disp_Valid = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (MIO_EN) begin
          accept     = 1'b1;
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        Mem_CE = is_sram;
        Mem_WE = is_sram && wr_q;
        // <=1 rather than ==1 so a zero count cannot wrap into a 16-cycle stall
        if (cnt <= 4'd1) begin
          capture    = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        R          = 1'b1;
        Disp_Valid = wr_q && (Mem_Addr == ADDR_DDR);
        next_state = RELEASE;
      end
      RELEASE: begin
        // Control holds MIO_EN until it sees R; wait for it to drop so the
        // same request is never served twice.
        if (!MIO_EN) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      wr_q      <= 1'b0;
      Mem_Addr  <= 16'h0000;
      Mem_Wdata <= 16'h0000;
      MDR_In    <= 16'h0000;
      Disp_Data <= 8'h00;
      kbsr_rdy  <= 1'b0;
      kbdr      <= 8'h00;
    end else begin
      state <= next_state;

      // Request fields are sampled only on acceptance; later changes are ignored.
      if (accept) begin
        Mem_Addr  <= MAR;
        Mem_Wdata <= MDR;
        wr_q      <= R_W;
        cnt       <= WAIT_LOAD;
      end else if (state == ACCESS) begin
        cnt <= cnt - 4'd1;
      end

      if (capture && !wr_q)
        MDR_In <= rd_mux(Mem_Addr, Mem_Rdata, kbsr_rdy, kbdr, Disp_Ready);

      if (capture && wr_q && (Mem_Addr == ADDR_DDR))
        Disp_Data <= Mem_Wdata[7:0];

      // A new keystroke beats a simultaneous KBDR-read clear; the read itself
      // still returns the previous character (sampled above from old kbdr).
      if (Kbd_Valid) begin
        kbsr_rdy <= 1'b1;
        kbdr     <= Kbd_Data;
      end else if (capture && !wr_q && (Mem_Addr == ADDR_KBDR)) begin
        kbsr_rdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_io_ctrl.sv
module tb_mem_io_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        MIO_EN = 1'b0;
  logic        R_W = 1'b0;
  logic [15:0] MAR = 16'h0000;
  logic [15:0] MDR = 16'h0000;
  logic [15:0] MDR_In;
  logic        R;
  logic [15:0] Mem_Addr;
  logic [15:0] Mem_Wdata;
  logic [15:0] Mem_Rdata;
  logic        Mem_CE;
  logic        Mem_WE;
  logic        Kbd_Valid = 1'b0;
  logic [7:0]  Kbd_Data = 8'h00;
  logic        Disp_Ready = 1'b0;
  logic        Disp_Valid;
  logic [7:0]  Disp_Data;

  int n_tests = 0;
  int n_fail  = 0;

  mem_io_ctrl #(.WAIT_STATES(2)) dut (
    .Clk(Clk), .Reset(Reset), .MIO_EN(MIO_EN), .R_W(R_W), .MAR(MAR), .MDR(MDR),
    .MDR_In(MDR_In), .R(R), .Mem_Addr(Mem_Addr), .Mem_Wdata(Mem_Wdata),
    .Mem_Rdata(Mem_Rdata), .Mem_CE(Mem_CE), .Mem_WE(Mem_WE),
    .Kbd_Valid(Kbd_Valid), .Kbd_Data(Kbd_Data), .Disp_Ready(Disp_Ready),
    .Disp_Valid(Disp_Valid), .Disp_Data(Disp_Data)
  );

  always #5 Clk = ~Clk;

  // Small SRAM model: asynchronous read, write on rising edge while Mem_WE.
  logic [15:0] sram [0:255];
  logic        preload = 1'b0;
  logic [7:0]  sidx;
  assign sidx      = {Mem_Addr[15:12], Mem_Addr[3:0]};
  assign Mem_Rdata = sram[sidx];
  always @(posedge Clk) begin
    if (preload) begin
      sram[8'h30] <= 16'hBEEF;
      sram[8'h40] <= 16'h0000;
    end else if (Mem_WE) begin
      sram[sidx] <= Mem_Wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Results of the most recent request
  logic [15:0] rd, addr_seen, wd_seen;
  int          r_cyc, ce_n, we_n, dv_n, dv_r;

  // One complete request. Inputs change on falling edges; outputs are sampled
  // on falling edges. kv_at>0 pulses Kbd_Valid with kv_d in that cycle offset.
  task automatic req(input logic rw, input logic [15:0] a, input logic [15:0] d,
                     input int kv_at, input logic [7:0] kv_d);
    @(negedge Clk);
    MIO_EN = 1'b1; R_W = rw; MAR = a; MDR = d;
    r_cyc = 0; ce_n = 0; we_n = 0; dv_n = 0; dv_r = 0;
    rd = 16'h0; addr_seen = 16'h0; wd_seen = 16'h0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge Clk);
      if (i == 1) begin
        MAR = 16'hDEAD; MDR = 16'h5555; R_W = ~rw;
      end
      Kbd_Valid = (i == kv_at);
      if (i == kv_at) Kbd_Data = kv_d;
      if (Mem_CE && ce_n == 0) begin
        addr_seen = Mem_Addr; wd_seen = Mem_Wdata;
      end
      if (Mem_CE) ce_n++;
      if (Mem_WE) we_n++;
      if (Disp_Valid) dv_n++;
      if (R) begin
        r_cyc = i; rd = MDR_In;
        if (Disp_Valid) dv_r++;
        break;
      end
    end
    MIO_EN = 1'b0; Kbd_Valid = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    int r_cnt, ce_cnt;

    // Reset state
    preload = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_R", R, 1'b0);
    chk("rst_CE", Mem_CE, 1'b0);
    chk("rst_WE", Mem_WE, 1'b0);
    chk("rst_DV", Disp_Valid, 1'b0);
    chk("rst_MDR_In", MDR_In, 16'h0000);
    chk("rst_Mem_Addr", Mem_Addr, 16'h0000);
    chk("rst_Disp_Data", Disp_Data, 8'h00);
    Reset = 1'b0; preload = 1'b0;

    // 1. SRAM read
    req(1'b0, 16'h3000, 16'h0000, 0, 8'h00);
    chk("rd_latency", r_cyc, 3);
    chk("rd_ce_cycles", ce_n, 2);
    chk("rd_we_cycles", we_n, 0);
    chk("rd_addr", addr_seen, 16'h3000);
    chk("rd_data", rd, 16'hBEEF);

    // 2. SRAM write, MDR_In held, read-back
    req(1'b1, 16'h4000, 16'h1234, 0, 8'h00);
    chk("wr_latency", r_cyc, 3);
    chk("wr_we_cycles", we_n, 2);
    chk("wr_addr", addr_seen, 16'h4000);
    chk("wr_wdata", wd_seen, 16'h1234);
    chk("wr_mdr_in_held", MDR_In, 16'hBEEF);
    req(1'b0, 16'h4000, 16'h0000, 0, 8'h00);
    chk("readback", rd, 16'h1234);

    // 3. Keyboard
    @(negedge Clk); Kbd_Valid = 1'b1; Kbd_Data = 8'h41;
    @(negedge Clk); Kbd_Valid = 1'b0;
    req(1'b0, 16'hFE00, 16'h0, 0, 8'h00);
    chk("kbsr_set", rd, 16'h8000);
    chk("kbsr_no_ce", ce_n, 0);
    req(1'b0, 16'hFE02, 16'h0, 0, 8'h00);
    chk("kbdr", rd, 16'h0041);
    chk("kbdr_no_ce", ce_n, 0);
    req(1'b0, 16'hFE00, 16'h0, 0, 8'h00);
    chk("kbsr_clr", rd, 16'h0000);

    // 4. Display
    Disp_Ready = 1'b1;
    req(1'b1, 16'hFE06, 16'h0058, 0, 8'h00);
    chk("ddr_dv_total", dv_n, 1);
    chk("ddr_dv_with_r", dv_r, 1);
    chk("ddr_no_ce", ce_n, 0);
    chk("disp_data", Disp_Data, 8'h58);
    req(1'b0, 16'hFE04, 16'h0, 0, 8'h00);
    chk("dsr_ready", rd, 16'h8000);
    Disp_Ready = 1'b0;
    req(1'b0, 16'hFE04, 16'h0, 0, 8'h00);
    chk("dsr_busy", rd, 16'h0000);
    req(1'b0, 16'hFE06, 16'h0, 0, 8'h00);
    chk("ddr_read_zero", rd, 16'h0000);
    req(1'b0, 16'hFE10, 16'h0, 0, 8'h00);
    chk("unmapped_read", rd, 16'h0000);
    chk("unmapped_latency", r_cyc, 3);

    // 5. MIO_EN held long after R
    r_cnt = 0; ce_cnt = 0;
    @(negedge Clk); MIO_EN = 1'b1; R_W = 1'b0; MAR = 16'h3000;
    for (int i = 0; i < 13; i++) begin
      @(negedge Clk);
      if (R) r_cnt++;
      if (Mem_CE) ce_cnt++;
    end
    MIO_EN = 1'b0;
    chk("hold_r_pulses", r_cnt, 1);
    chk("hold_ce_cycles", ce_cnt, 4'd2);
    @(negedge Clk);
    req(1'b0, 16'h4000, 16'h0, 0, 8'h00);
    chk("hold_next_latency", r_cyc, 3);
    chk("hold_next_data", rd, 16'h1234);

    // 6. Reset mid-access (with a pending keystroke that must be cleared)
    @(negedge Clk); Kbd_Valid = 1'b1; Kbd_Data = 8'h7A;
    @(negedge Clk); Kbd_Valid = 1'b0; MIO_EN = 1'b1; R_W = 1'b0; MAR = 16'h3000;
    @(negedge Clk);
    chk("pre_rst_ce", Mem_CE, 1'b1);
    Reset = 1'b1;
    @(negedge Clk);
    chk("rst_mid_ce", Mem_CE, 1'b0);
    r_cnt = (R === 1'b1) ? 1 : 0;
    Reset = 1'b0; MIO_EN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (R) r_cnt++;
    end
    chk("rst_mid_no_r", r_cnt, 0);
    req(1'b0, 16'hFE00, 16'h0, 0, 8'h00);
    chk("rst_mid_idle_latency", r_cyc, 3);
    chk("rst_mid_kbsr_clr", rd, 16'h0000);

    // Keystroke coincident with the KBDR-read clear
    @(negedge Clk); Kbd_Valid = 1'b1; Kbd_Data = 8'h42;
    @(negedge Clk); Kbd_Valid = 1'b0;
    req(1'b0, 16'hFE02, 16'h0, 2, 8'h43);
    chk("race_old_char", rd, 16'h0042);
    req(1'b0, 16'hFE00, 16'h0, 0, 8'h00);
    chk("race_kbsr_kept", rd, 16'h8000);
    req(1'b0, 16'hFE02, 16'h0, 0, 8'h00);
    chk("race_new_char", rd, 16'h0043);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
